// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes, FSM
// states and the layout of the status bits stored above the data in each FIFO word.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_e;

    // Offsets above the data field: word = {break, parity_err, framing_err, data}.
    localparam int STAT_FRM_OFS = 0;
    localparam int STAT_PAR_OFS = 1;
    localparam int STAT_BRK_OFS = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO; an extra pointer wrap bit
// distinguishes full from empty. A push while full is accepted only with a pop.
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i && (!full_o || pop_i)) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ms.sv
// Parametrised UART receiver with 3-sample majority voting, parity/framing/break
// detection and a FWFT output FIFO of per-frame status words.
module uart_rx_ms
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick16,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 break_detect,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy,
    output logic                 overrun
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int W  = DATA_BITS + 3;
    localparam logic [SW-1:0] SUB_A    = SW'(M - 1);
    localparam logic [SW-1:0] SUB_B    = SW'(M);
    localparam logic [SW-1:0] SUB_C    = SW'(M + 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(OVERSAMPLE - 1);

    rx_state_e            state_q;
    logic [1:0]           sync_q;
    logic [SW-1:0]        sub_q;
    logic [3:0]           bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 samp_a_q, samp_b_q;
    logic                 par_bit_q, par_err_q, frm_err_q;
    logic                 push_q;
    logic [W-1:0]         push_word_q;
    logic                 overrun_q;

    logic         rx_s, maj, exp_par;
    logic         fifo_full, fifo_empty, fifo_pop;
    logic [W-1:0] head;

    assign rx_s    = sync_q[1];
    assign maj     = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);
    assign exp_par = (^shift_q) ^ (PARITY == PAR_ODD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sync_q      <= 2'b11;
            sub_q       <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            samp_a_q    <= 1'b1;
            samp_b_q    <= 1'b1;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            sync_q <= {sync_q[0], rx};
            push_q <= 1'b0;
            if (tick16) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state_q <= ST_START;
                            sub_q   <= '0;
                        end
                    end
                    ST_BREAK_WAIT: begin
                        if (rx_s) state_q <= ST_IDLE;
                    end
                    default: begin
                        sub_q <= (sub_q == SUB_LAST) ? '0 : sub_q + SW'(1);
                        if (sub_q == SUB_A) samp_a_q <= rx_s;
                        if (sub_q == SUB_B) samp_b_q <= rx_s;
                        case (state_q)
                            ST_START: begin
                                if (sub_q == SUB_C && maj) begin
                                    state_q <= ST_IDLE;
                                end else if (sub_q == SUB_LAST) begin
                                    state_q    <= ST_DATA;
                                    bit_idx_q  <= '0;
                                    stop_idx_q <= 1'b0;
                                    par_bit_q  <= 1'b0;
                                    par_err_q  <= 1'b0;
                                    frm_err_q  <= 1'b0;
                                end
                            end
                            ST_DATA: begin
                                if (sub_q == SUB_C) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                                if (sub_q == SUB_LAST) begin
                                    if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                                        bit_idx_q <= '0;
                                        if (PARITY == PAR_NONE) state_q <= ST_STOP;
                                        else                    state_q <= ST_PARITY;
                                    end else begin
                                        bit_idx_q <= bit_idx_q + 4'd1;
                                    end
                                end
                            end
                            ST_PARITY: begin
                                if (sub_q == SUB_C) begin
                                    par_bit_q <= maj;
                                    par_err_q <= maj ^ exp_par;
                                end
                                if (sub_q == SUB_LAST) state_q <= ST_STOP;
                            end
                            ST_STOP: begin
                                if (sub_q == SUB_C) begin
                                    // A break is recognised on the first stop bit and
                                    // ends the frame early; the line is then held off.
                                    if (!stop_idx_q && !maj && shift_q == '0 && !par_bit_q) begin
                                        push_q      <= 1'b1;
                                        push_word_q <= {1'b1, par_err_q, 1'b1, shift_q};
                                        state_q     <= ST_BREAK_WAIT;
                                    end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                                        push_q      <= 1'b1;
                                        push_word_q <= {1'b0, par_err_q, frm_err_q | ~maj, shift_q};
                                        state_q     <= ST_IDLE;
                                    end else begin
                                        frm_err_q <= frm_err_q | ~maj;
                                    end
                                end else if (sub_q == SUB_LAST) begin
                                    stop_idx_q <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

    assign fifo_pop = valid & ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) overrun_q <= 1'b0;
        else          overrun_q <= push_q & fifo_full & ~fifo_pop;
    end

    uart_rx_fifo #(
        .WIDTH(W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_q),
        .wdata_i (push_word_q),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign data          = head[DATA_BITS-1:0];
    assign framing_error = head[DATA_BITS + STAT_FRM_OFS];
    assign parity_error  = head[DATA_BITS + STAT_PAR_OFS];
    assign break_detect  = head[DATA_BITS + STAT_BRK_OFS];
    assign valid         = ~fifo_empty;
    assign busy          = (state_q != ST_IDLE);
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_ms.sv
// Directed bench for uart_rx_ms: an 8N1 instance and a 7E2 instance share one
// clock and a tick16 strobe every 4 clk (one bit = 64 clk).
module tb_uart_rx_ms;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] tcnt = 2'd0;
    logic       tick16;

    logic       rx, ready;
    logic [7:0] data;
    logic       parity_error, framing_error, break_detect, valid, busy, overrun;

    logic       rx_p, ready_p;
    logic [6:0] data_p;
    logic       parity_error_p, framing_error_p, break_detect_p, valid_p, busy_p, overrun_p;

    logic [10:0] got_q[$];
    logic [9:0]  got_p[$];
    int n_ovr    = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tcnt <= tcnt + 2'd1;
    assign tick16 = (tcnt == 2'd3);

    uart_rx_ms #(.OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .tick16(tick16), .rx(rx),
        .data(data), .parity_error(parity_error), .framing_error(framing_error),
        .break_detect(break_detect), .valid(valid), .ready(ready),
        .busy(busy), .overrun(overrun)
    );

    uart_rx_ms #(.OVERSAMPLE(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_p (
        .clk(clk), .reset_n(reset_n), .tick16(tick16), .rx(rx_p),
        .data(data_p), .parity_error(parity_error_p), .framing_error(framing_error_p),
        .break_detect(break_detect_p), .valid(valid_p), .ready(ready_p),
        .busy(busy_p), .overrun(overrun_p)
    );

    // Pops happen at the posedge following a negedge where valid & ready hold.
    always @(negedge clk) begin
        if (valid && ready)     got_q.push_back({break_detect, parity_error, framing_error, data});
        if (valid_p && ready_p) got_p.push_back({break_detect_p, parity_error_p, framing_error_p, data_p});
        if (overrun) n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int sel, input logic b);
        if (sel == 0) rx = b;
        else          rx_p = b;
    endtask

    task automatic drive_bit(input int sel, input logic b, input bit glitch);
        set_line(sel, b);
        if (glitch && b) begin
            wait_clk(30);
            set_line(sel, 1'b0);
            wait_clk(4);
            set_line(sel, b);
            wait_clk(BIT_CLK - 34);
        end else begin
            wait_clk(BIT_CLK);
        end
    endtask

    task automatic send_frame(input int sel, input logic [8:0] d, input int nbits,
                              input bit has_par, input logic pbit, input int nstop,
                              input int glitch_bit);
        drive_bit(sel, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, d[i], i == glitch_bit);
        if (has_par) drive_bit(sel, pbit, 1'b0);
        for (int i = 0; i < nstop; i++) drive_bit(sel, 1'b1, 1'b0);
    endtask

    initial begin
        int t;
        reset_n = 1'b0;
        rx      = 1'b1;
        rx_p    = 1'b1;
        ready   = 1'b0;
        ready_p = 1'b1;
        wait_clk(5);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_data", data, 0);
        check("rst_flags", {break_detect, parity_error, framing_error}, 0);
        check("rst_valid_p", valid_p, 0);
        reset_n = 1'b1;
        wait_clk(20);

        // Back-to-back 8N1 frames
        ready = 1'b1;
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, -1);
        send_frame(0, 9'h03C, 8, 0, 1'b0, 1, -1);
        wait_clk(128);
        check("b2b_count", got_q.size(), 2);
        check("b2b_first", got_q[0], 11'h0A5);
        check("b2b_second", got_q[1], 11'h03C);
        check("b2b_valid_low", valid, 0);

        // 7E2: wrong parity bit, then correct one (0x55 has four ones)
        send_frame(1, 9'h055, 7, 1, 1'b1, 2, -1);
        send_frame(1, 9'h055, 7, 1, 1'b0, 2, -1);
        wait_clk(128);
        check("par_count", got_p.size(), 2);
        check("par_bad", got_p[0], 10'h155);
        check("par_good", got_p[1], 10'h055);

        // False start: 4 ticks low
        got_q.delete();
        rx = 1'b0;
        wait_clk(16);
        check("false_start_busy_hi", busy, 1);
        rx = 1'b1;
        t = 0;
        while (busy && t < 100) begin
            wait_clk(1);
            t++;
        end
        check("false_start_busy_lo", busy, 0);
        wait_clk(BIT_CLK * 2);
        check("false_start_nopush", got_q.size(), 0);

        // Short low glitches inside '1' data bits are voted out
        send_frame(0, 9'h081, 8, 0, 1'b0, 1, 0);
        send_frame(0, 9'h0FF, 8, 0, 1'b0, 1, 4);
        wait_clk(128);
        check("glitch_count", got_q.size(), 2);
        check("glitch_bit0", got_q[0], 11'h081);
        check("glitch_bit4", got_q[1], 11'h0FF);

        // Break: line low for two frame times
        got_q.delete();
        rx = 1'b0;
        wait_clk(BIT_CLK * 20);
        rx = 1'b1;
        wait_clk(BIT_CLK * 2);
        check("break_count", got_q.size(), 1);
        check("break_word", got_q[0], 11'h500);
        check("break_busy", busy, 0);
        send_frame(0, 9'h042, 8, 0, 1'b0, 1, -1);
        wait_clk(128);
        check("break_resume_count", got_q.size(), 2);
        check("break_resume_data", got_q[1], 11'h042);

        // Overflow a 4-deep FIFO with ready low
        got_q.delete();
        ready = 1'b0;
        n_ovr = 0;
        for (int v = 1; v <= 5; v++) begin
            send_frame(0, 9'(v), 8, 0, 1'b0, 1, -1);
            wait_clk(BIT_CLK);
        end
        check("ovr_valid", valid, 1);
        check("ovr_head", data, 8'h01);
        check("ovr_pulses", n_ovr, 1);
        ready = 1'b1;
        wait_clk(10);
        check("drain_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) check("drain_data", got_q[i], 11'(i + 1));
        check("drain_valid", valid, 0);

        // Reset mid-frame with a stale entry already queued
        got_q.delete();
        ready = 1'b0;
        send_frame(0, 9'h011, 8, 0, 1'b0, 1, -1);
        wait_clk(BIT_CLK);
        check("stale_valid", valid, 1);
        rx = 1'b0;
        wait_clk(BIT_CLK * 4 + 32);
        reset_n = 1'b0;
        wait_clk(4);
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        rx = 1'b1;
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(BIT_CLK);
        ready = 1'b1;
        send_frame(0, 9'h07E, 8, 0, 1'b0, 1, -1);
        wait_clk(128);
        check("midrst_count", got_q.size(), 1);
        check("midrst_data", got_q[0], 11'h07E);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ms.md
# uart_rx_ms

Parametrised UART receiver, the successor to the fixed 8N1 receiver. It supports configurable data width, parity and stop-bit count, and uses 3-sample majority voting per bit. It detects break conditions and buffers received frames with per-frame status in a small FIFO behind a valid/ready interface. It sits between the pad-level RX pin and the command parser of the motor-PID control path, and consumes the shared BAUD×OVERSAMPLE tick.

## Interface
- OVERSAMPLE, 16: ticks per bit; even, ≥8.
- DATA_BITS, 8: data bits per frame, 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: output FIFO entries; power of 2, ≥2.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick16  in  1  one-clk strobe at BAUD×OVERSAMPLE.
- rx  in  1  asynchronous serial input; idle high.
- data  out  DATA_BITS  head-of-FIFO data.
- parity_error  out  1  head frame had a parity mismatch.
- framing_error  out  1  head frame had a stop bit (any) sampled low.
- break_detect  out  1  head frame was a break.
- valid  out  1  FIFO not empty; head fields are valid.
- ready  in  1  consumer accepts the head; pops on valid & ready.
- busy  out  1  receiver is not in IDLE.
- overrun  out  1  one-clk pulse when a completed frame is dropped because the FIFO is full.

## Operation
- Two-FF synchroniser on rx; both FFs reset to 1. All FSM logic uses the synchronised rx_s and advances only on tick16.
- Bit counter `sub` runs 0..OVERSAMPLE-1 within each bit. Let M = OVERSAMPLE/2.
  - rx_s is sampled at sub = M-1, M and M+1.
  - The bit value is the 2-of-3 majority, fixed at sub = M+1.
- FSM states and transitions:
  - IDLE: on rx_s = 0, go to START with sub = 0 and busy = 1.
  - START: if the majority is 1 at sub = M+1, go back to IDLE (false start, nothing pushed). Otherwise advance at sub = OVERSAMPLE-1.
  - DATA: shift the majority bit into the shift register, LSB first. After DATA_BITS bits, go to PARITY, or to STOP if PARITY = 0.
  - PARITY: expected = XOR of the data bits, inverted for odd parity. A mismatch sets the frame's parity_error.
  - STOP: sample each stop bit; any stop bit low sets framing_error.
- The final stop bit exits to IDLE at sub = M+1, without waiting for the end of the bit. This allows resynchronisation to a back-to-back start edge.
- Break: data bits all 0, parity bit 0 (if present) and first stop bit 0. break_detect = 1 and framing_error = 1.
  - After a break frame, the receiver stays in a BREAK_WAIT state until rx_s = 1 for one tick, then returns to IDLE.
  - busy stays 1 in BREAK_WAIT.
- Every completed frame, with or without errors, is pushed as {break, parity_err, framing_err, data}.
- Push when full:
  - If ready & valid in the same clk: pop and push both proceed.
  - Otherwise the new frame is dropped, the FIFO contents are unchanged, and overrun pulses for one clk.
- FIFO is first-word-fall-through. Head fields are undefined (held at last value) when valid = 0.

## Timing
- Reset (async assert, sync deassert handled externally): FSM to IDLE, sub/bit index/shift register to 0, FIFO empty.
  - Outputs after reset: valid 0, busy 0, overrun 0, data 0, all status flags 0.
- Frame decision at clk edge E (the tick with sub = M+1 of the last stop bit). The push is registered, so valid rises after edge E+1. Frame-end-to-valid latency is 2 clk.
- A pop takes effect at the edge where valid & ready. The next head, or valid = 0, is visible the following cycle.
- busy falls at edge E. A start edge sampled at the next tick is accepted.
- Reset asserted mid-frame aborts the frame. Nothing is pushed and the FIFO is cleared.
- Minimum rx-to-FSM latency is 2 clk (synchroniser).

## Structure
- Package uart_pkg holds:
  - parity mode constants (PAR_NONE/PAR_EVEN/PAR_ODD)
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT)
  - the status-field bit positions of the FIFO word
- Sub-module uart_rx_fifo: generic synchronous FWFT FIFO.
  - Parameters: WIDTH, DEPTH.
  - Signals: push/pop/full/empty, with a pointer wrap bit for the full/empty distinction.
  - Instantiated with WIDTH = DATA_BITS+3.

## Test plan
- 8N1, OVERSAMPLE 16, send 0xA5 then 0x3C back-to-back, ready = 1 → two valid pulses, data 0xA5 then 0x3C, all flags 0.
- PARITY = 1 (even), DATA_BITS 7, STOP_BITS 2, send 0x55 with parity bit 1 → data 0x55, parity_error = 1. Correct parity bit 0 → parity_error = 0.
- rx low for 4 ticks then high → no push, busy returns to 0 at the tick after sub = M+1. A 1-tick low glitch at sub = M inside a '1' data bit → bit still read as 1.
- Hold rx low for 2 frame times, then high → one entry with break_detect = 1, framing_error = 1, data 0. Only one entry appears, and the receiver resumes with the next frame.
- FIFO_DEPTH 4, ready = 0, send 5 frames 0x01..0x05 → valid = 1 with 4 entries 0x01..0x04, overrun pulses once at the 5th frame. Drain with ready = 1 → 0x01..0x04 in order, then valid = 0.
- Assert reset_n = 0 during DATA bit 3, release, send 0x7E → only 0x7E is received, no stale entry, and no flags set.
